shreg_engine: RTL and testbench

- Parametrised successor to the single-bit D flip-flop cell: a WIDTH-bit universal shift register.
- Per-cycle modes: hold, shift left/right, parallel load, rotate left/right.
- Auto-run engine: performs a programmed count of shift/rotate operations, then reports completion.
- Used as a serialiser/deserialiser and bit-manipulation building block in the sequential library.

---
 rtl/shreg_engine.sv | 156 +++++++++++++++
 tb/tb_shreg_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shreg_engine.sv
// ---------------------------------------------------------------------------
// shreg_engine: WIDTH-bit universal shift register with an auto-run engine.
//
// Per-cycle modes (MODE): 000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROTL,
// 101 ROTR, 110/111 HOLD. A START pulse in IDLE with a shift/rotate MODE and
// NUM != 0 latches the operation and runs it NUM times, then pulses DONE.
//
// Ports:
//   CP     in   clock, rising edge
//   RST    in   asynchronous reset, active low
//   CLR    in   synchronous clear (aborts a run, no DONE)
//   MODE   in   [2:0] operation select
//   D      in   [WIDTH-1:0] parallel load data
//   SIL    in   serial in for SHL (enters bit 0)
//   SIR    in   serial in for SHR (enters bit WIDTH-1)
//   START  in   auto-run request pulse
//   NUM    in   [CNT_W-1:0] auto-run operation count
//   Q      out  [WIDTH-1:0] register contents
//   SO_L   out  Q[WIDTH-1]
//   SO_R   out  Q[0]
//   BUSY   out  auto-run in progress
//   DONE   out  one-cycle completion pulse
//   PAR    out  XOR-reduction of Q when SHREG_PARITY_EN is defined, else 0
//
// Optional feature macro: SHREG_PARITY_EN
// ---------------------------------------------------------------------------
module shreg_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             CLR,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    input  logic             START,
    input  logic [CNT_W-1:0] NUM,
    output logic [WIDTH-1:0] Q,
    output logic             SO_L,
    output logic             SO_R,
    output logic             BUSY,
    output logic             DONE,
    output logic             PAR
);

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeShl  = 3'b001;
    localparam logic [2:0] ModeShr  = 3'b010;
    localparam logic [2:0] ModeLoad = 3'b011;
    localparam logic [2:0] ModeRotl = 3'b100;
    localparam logic [2:0] ModeRotr = 3'b101;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic             sil,
                                                  input logic             sir);
        logic [WIDTH-1:0] r;
        case (op)
            ModeShl:  r = {q[WIDTH-2:0], sil};
            ModeShr:  r = {sir, q[WIDTH-1:1]};
            ModeLoad: r = d;
            ModeRotl: r = {q[WIDTH-2:0], q[WIDTH-1]};
            ModeRotr: r = {q[0], q[WIDTH-1:1]};
            default:  r = q;
        endcase
        return r;
    endfunction

    // Only shifts and rotates can be repeated by the engine.
    function automatic logic is_auto_op(input logic [2:0] op);
        return (op == ModeShl) || (op == ModeShr) || (op == ModeRotl) || (op == ModeRotr);
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;

        if (CLR) begin
            q_d     = '0;
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            q_d   = apply_op(op_q, q_q, D, SIL, SIR);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end else if (START && (NUM != '0) && is_auto_op(MODE)) begin
            // Accepting edge: Q is left untouched, first shift happens next edge.
            op_d    = MODE;
            cnt_d   = NUM;
            state_d = StRun;
        end else begin
            q_d = apply_op(MODE, q_q, D, SIL, SIR);
        end
    end

    always_ff @(posedge CP or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= ModeHold;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

`ifdef SHREG_PARITY_EN
    logic par_q, par_d;

    // Taken from next-Q so parity always matches the Q it accompanies.
    always_comb begin
        par_d = ^q_d;
    end

    always_ff @(posedge CP or negedge RST) begin
        if (!RST) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign PAR = par_q;
`else
    assign PAR = 1'b0;
`endif

    assign Q    = q_q;
    assign SO_L = q_q[WIDTH-1];
    assign SO_R = q_q[0];
    assign BUSY = (state_q == StRun);
    assign DONE = done_q;

endmodule

// File: tb/tb_shreg_engine.sv
// ---------------------------------------------------------------------------
// tb_shreg_engine: directed, self-checking bench for shreg_engine (WIDTH=8).
// Each step pushes the expected post-edge state onto a scoreboard queue, then
// pops it one edge later and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_shreg_engine;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] MHold = 3'b000;
    localparam logic [2:0] MShl  = 3'b001;
    localparam logic [2:0] MShr  = 3'b010;
    localparam logic [2:0] MLoad = 3'b011;
    localparam logic [2:0] MRotl = 3'b100;
    localparam logic [2:0] MRotr = 3'b101;

    logic             CP;
    logic             RST;
    logic             CLR;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SIL;
    logic             SIR;
    logic             START;
    logic [CNT_W-1:0] NUM;
    logic [WIDTH-1:0] Q;
    logic             SO_L;
    logic             SO_R;
    logic             BUSY;
    logic             DONE;
    logic             PAR;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    shreg_engine #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .CP   (CP),
        .RST  (RST),
        .CLR  (CLR),
        .MODE (MODE),
        .D    (D),
        .SIL  (SIL),
        .SIR  (SIR),
        .START(START),
        .NUM  (NUM),
        .Q    (Q),
        .SO_L (SO_L),
        .SO_R (SO_R),
        .BUSY (BUSY),
        .DONE (DONE),
        .PAR  (PAR)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    function automatic logic par_of(input logic [WIDTH-1:0] q);
`ifdef SHREG_PARITY_EN
        return ^q;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push expectation, clock once, pop and compare.
    task automatic step(input string tag, input logic [WIDTH-1:0] q, input logic busy,
                        input logic done);
        exp_t e;
        exp_q.push_back('{q: q, busy: busy, done: done});
        @(posedge CP);
        #1;
        e = exp_q.pop_front();
        check({tag, ".Q"}, 32'(Q), 32'(e.q));
        check({tag, ".BUSY"}, 32'(BUSY), 32'(e.busy));
        check({tag, ".DONE"}, 32'(DONE), 32'(e.done));
        check({tag, ".PAR"}, 32'(PAR), 32'(par_of(e.q)));
        check({tag, ".SO_L"}, 32'(SO_L), 32'(e.q[WIDTH-1]));
        check({tag, ".SO_R"}, 32'(SO_R), 32'(e.q[0]));
    endtask

    task automatic drive(input logic [2:0] mode, input logic [WIDTH-1:0] d, input logic sil,
                         input logic sir, input logic start, input logic [CNT_W-1:0] num);
        MODE  = mode;
        D     = d;
        SIL   = sil;
        SIR   = sir;
        START = start;
        NUM   = num;
    endtask

    initial begin
        RST = 1'b0;
        CLR = 1'b0;
        drive(MHold, '0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        check("reset.Q", 32'(Q), 32'h0);
        check("reset.BUSY", 32'(BUSY), 32'h0);
        check("reset.DONE", 32'(DONE), 32'h0);
        check("reset.PAR", 32'(PAR), 32'h0);
        #10 RST = 1'b1;

        // Manual operations
        drive(MLoad, 8'hA5, 1'b0, 1'b0, 1'b0, '0); step("load_a5", 8'hA5, 1'b0, 1'b0);
        drive(MShl, '0, 1'b1, 1'b0, 1'b0, '0);     step("shl", 8'h4B, 1'b0, 1'b0);
        drive(MShr, '0, 1'b0, 1'b0, 1'b0, '0);     step("shr", 8'h25, 1'b0, 1'b0);
        drive(MRotr, '0, 1'b0, 1'b0, 1'b0, '0);    step("rotr", 8'h92, 1'b0, 1'b0);
        drive(MHold, 8'hFF, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step("hold", 8'h92, 1'b0, 1'b0);
        drive(3'b110, 8'hFF, 1'b1, 1'b1, 1'b0, '0); step("mode110", 8'h92, 1'b0, 1'b0);
        drive(3'b111, 8'hFF, 1'b1, 1'b1, 1'b0, '0); step("mode111", 8'h92, 1'b0, 1'b0);

        // Parity
        drive(MLoad, 8'h07, 1'b0, 1'b0, 1'b0, '0); step("par_load07", 8'h07, 1'b0, 1'b0);
        drive(MRotl, '0, 1'b0, 1'b0, 1'b0, '0);    step("par_rotl", 8'h0E, 1'b0, 1'b0);

        // Auto-run ROTL x3
        drive(MLoad, 8'h81, 1'b0, 1'b0, 1'b0, '0); step("run_load", 8'h81, 1'b0, 1'b0);
        drive(MRotl, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd3); step("run_t", 8'h81, 1'b1, 1'b0);
        drive(MLoad, 8'hFF, 1'b1, 1'b1, 1'b0, '0);
        step("run_t1", 8'h03, 1'b1, 1'b0);
        step("run_t2", 8'h06, 1'b1, 1'b0);
        drive(MHold, 8'hFF, 1'b1, 1'b1, 1'b0, '0);
        step("run_t3", 8'h0C, 1'b0, 1'b1);
        step("run_after", 8'h0C, 1'b0, 1'b0);

        // START mid-run ignored, then back-to-back START in the DONE cycle
        drive(MLoad, 8'h81, 1'b0, 1'b0, 1'b0, '0);   step("mid_load", 8'h81, 1'b0, 1'b0);
        drive(MRotr, '0, 1'b0, 1'b0, 1'b1, 4'd2);    step("mid_t", 8'h81, 1'b1, 1'b0);
        drive(MShl, '0, 1'b1, 1'b0, 1'b1, 4'd7);     step("mid_t1", 8'hC0, 1'b1, 1'b0);
        drive(MHold, '0, 1'b1, 1'b0, 1'b0, '0);      step("mid_t2", 8'h60, 1'b0, 1'b1);
        drive(MShl, '0, 1'b1, 1'b0, 1'b1, 4'd1);     step("b2b_t", 8'h60, 1'b1, 1'b0);
        drive(MHold, '0, 1'b1, 1'b0, 1'b0, '0);      step("b2b_t1", 8'hC1, 1'b0, 1'b1);
        step("b2b_after", 8'hC1, 1'b0, 1'b0);

        // Ignored starts still apply MODE
        drive(MShl, '0, 1'b0, 1'b0, 1'b1, 4'd0);     step("ign_num0", 8'h82, 1'b0, 1'b0);
        drive(MLoad, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd5); step("ign_load", 8'h3C, 1'b0, 1'b0);
        drive(MHold, '0, 1'b0, 1'b0, 1'b0, '0);      step("ign_after", 8'h3C, 1'b0, 1'b0);

        // CLR abort
        drive(MLoad, 8'hFF, 1'b0, 1'b0, 1'b0, '0);   step("clr_load", 8'hFF, 1'b0, 1'b0);
        drive(MShr, '0, 1'b0, 1'b0, 1'b1, 4'd6);     step("clr_t", 8'hFF, 1'b1, 1'b0);
        drive(MHold, '0, 1'b0, 1'b0, 1'b0, '0);      step("clr_t1", 8'h7F, 1'b1, 1'b0);
        CLR = 1'b1;                                  step("clr_t2", 8'h00, 1'b0, 1'b0);
        CLR = 1'b0;
        for (int i = 0; i < 6; i++) step("clr_nodone", 8'h00, 1'b0, 1'b0);

        // Async reset mid-run
        drive(MLoad, 8'h5A, 1'b0, 1'b0, 1'b0, '0);   step("rst_load", 8'h5A, 1'b0, 1'b0);
        drive(MShl, '0, 1'b0, 1'b0, 1'b1, 4'd5);     step("rst_t", 8'h5A, 1'b1, 1'b0);
        drive(MHold, '0, 1'b0, 1'b0, 1'b0, '0);      step("rst_t1", 8'hB4, 1'b1, 1'b0);
        #3 RST = 1'b0;
        #1;
        check("async_rst.Q", 32'(Q), 32'h0);
        check("async_rst.BUSY", 32'(BUSY), 32'h0);
        check("async_rst.DONE", 32'(DONE), 32'h0);
        check("async_rst.PAR", 32'(PAR), 32'h0);
        #2 RST = 1'b1;
        for (int i = 0; i < 6; i++) step("rst_nodone", 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
